reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port general-purpose register file, successor to the fixed three-register A/B/C block. It provides one synchronous write port and NUM_RD registered read ports, plus a per-register busy scoreboard so the control unit can track in-flight producers. It sits between the control unit (address, enable and reserve strobes) and the data path (ALU operands and result write-back).

Parameters:
WORD_SIZE, 19, data width in bits (from constants package)
NUM_REGS, 8, number of architectural registers; any value 2..32, not necessarily a power of two
NUM_RD, 2, number of independent read ports, 1..4
ADDR_W, $clog2(NUM_REGS), derived localparam, not overridable

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write register index
wr_data  in  WORD_SIZE  write data
rsv_en  in  1  reserve strobe; marks rsv_addr busy
rsv_addr  in  ADDR_W  register index to reserve
rd_en  in  NUM_RD  per-port read strobe
rd_addr  in  NUM_RD*ADDR_W  packed read indices; port p uses bits [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*WORD_SIZE  packed registered read data
rd_valid  out  NUM_RD  per-port: rd_data updated this cycle
rd_busy  out  NUM_RD  per-port: register read was busy at sample time
busy_vec  out  NUM_REGS  live scoreboard, one bit per register

Behaviour:
- Reset (async assert, sync-to-CLK deassert handled upstream): all registers 0, busy_vec 0, rd_data 0, rd_valid 0, rd_busy 0. Reset mid-operation discards pending reads and reservations immediately.
- Write: wr_en=1 at edge with wr_addr<NUM_REGS -> reg[wr_addr]<=wr_data, busy[wr_addr]<=0. wr_addr>=NUM_REGS -> write ignored, no state change.
- Reserve: rsv_en=1 with rsv_addr<NUM_REGS -> busy[rsv_addr]<=1. Out-of-range reserve is ignored.
- Reserve and write to the same address in the same cycle: write data is stored and busy ends 1, because the reservation belongs to a newer producer. Different addresses are independent.
- Read: 1-cycle latency. rd_en[p]=1 at edge N -> at N+1 rd_data[p] = register value before edge N's write (no bypass by default), rd_busy[p] = busy bit before edge N, rd_valid[p]=1.
- rd_en[p]=0 -> rd_valid[p]<=0 and rd_data[p]/rd_busy[p] hold their previous values.
- Out-of-range read index: rd_data[p]<=0, rd_busy[p]<=0, rd_valid[p]<=1.
- Multiple ports may read the same register in the same cycle; each returns identical data.
- busy_vec is the registered scoreboard state, visible combinationally from the flops. It is not masked by the current-cycle inputs.
- The block contains no FSM. State is the register array, the scoreboard and the per-port output registers.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. If wr_en=1 and wr_addr==rd_addr[p] (in range) at the same edge as rd_en[p], then rd_data[p] = wr_data. rd_busy[p] then reflects the post-write busy value, which is 0 unless the same-cycle reserve case applies, in which case it is 1.
- Undefined: reads return the pre-write value, and rd_busy returns the pre-edge busy bit.

Decomposition:
- Shared package regfile_pkg:
  - REGFILE_NUM_REGS_DEF and REGFILE_NUM_RD_DEF defaults.
  - typedef word_t = logic [WORD_SIZE-1:0], reusing WORD_SIZE from constants.
  - Legacy index constants REG_A=0, REG_B=1, REG_C=2, so existing decode stays valid.
- One natural sub-module: reg_file_rd_port.
  - One per read port, generated NUM_RD times.
  - Holds the per-port output flops, the range check and, when enabled, the bypass mux.
- The top module holds the array, the write logic and the scoreboard.

Test Plan:
- Reset with all registers preloaded to 19'h7FFFF, then assert RST mid-cycle -> rd_data=0, rd_valid=0 and busy_vec=0 immediately, before the next edge.
- Write 19'h12345 to r5; next cycle read r5 on port 0 and r5 on port 1 -> both ports show 19'h12345 one cycle later with rd_valid=2'b11.
- Reserve r3 -> busy_vec[3]=1; read r3 -> rd_busy[0]=1; write r3=19'h00ABC -> busy_vec[3]=0; read r3 -> 19'h00ABC with rd_busy=0.
- Same cycle: rsv_en and wr_en both on r2 with data 19'h00007 -> reg[2]=19'h00007 and busy_vec[2]=1.
- NUM_REGS=6 build: write addr 7 with 19'h55555, then read addr 7 -> rd_data=0, rd_valid=1, no register changed.
- Same-edge write of 19'h0F0F0 and read of r1, which previously held 19'h00001:
  - without REGFILE_BYPASS_EN -> 19'h00001;
  - with REGFILE_BYPASS_EN -> 19'h0F0F0.

Source files
------------

// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared datapath constants
package constants_pkg;
    localparam int WORD_SIZE = 19;
endpackage

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file defaults, word type and legacy register indices
package regfile_pkg;
    import constants_pkg::WORD_SIZE;

    localparam int REGFILE_NUM_REGS_DEF = 8;
    localparam int REGFILE_NUM_RD_DEF   = 2;

    typedef logic [WORD_SIZE-1:0] word_t;

    // Indices of the old fixed A/B/C registers, kept so existing decode maps unchanged.
    localparam int REG_A = 0;
    localparam int REG_B = 1;
    localparam int REG_C = 2;
endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - one registered read port with range check
// Optional write-to-read forwarding under macro REGFILE_BYPASS_EN.
module reg_file_rd_port #(
    parameter int WORD_SIZE = 19,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_SIZE-1:0] regs [NUM_REGS],
    input  logic [NUM_REGS-1:0]  busy_cur,
`ifdef REGFILE_BYPASS_EN
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [NUM_REGS-1:0]  busy_next,
`endif
    output logic [WORD_SIZE-1:0] data,
    output logic                 valid,
    output logic                 busy
);
    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

    logic                 in_range;
    logic [WORD_SIZE-1:0] sel_data;
    logic                 sel_busy;

    assign in_range = {1'b0, addr} < NUM_REGS_W;

    always_comb begin
        sel_data = '0;
        sel_busy = 1'b0;
        if (in_range) begin
            sel_data = regs[addr];
            sel_busy = busy_cur[addr];
`ifdef REGFILE_BYPASS_EN
            // An in-range match implies the write address is in range too.
            if (wr_en && (wr_addr == addr)) begin
                sel_data = wr_data;
                sel_busy = busy_next[addr];
            end
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                data <= sel_data;
                busy <= sel_busy;
            end
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with busy scoreboard
// Read ports forward same-edge writes when macro REGFILE_BYPASS_EN is defined.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE = constants_pkg::WORD_SIZE,
    parameter int NUM_REGS  = REGFILE_NUM_REGS_DEF,
    parameter int NUM_RD    = REGFILE_NUM_RD_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [WORD_SIZE-1:0]        wr_data,
    input  logic                        rsv_en,
    input  logic [ADDR_W-1:0]           rsv_addr,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
    output logic [NUM_RD-1:0]           rd_valid,
    output logic [NUM_RD-1:0]           rd_busy,
    output logic [NUM_REGS-1:0]         busy_vec
);
    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

    logic [WORD_SIZE-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  busy_next;
    logic                 wr_ok;
    logic                 rsv_ok;

    assign wr_ok    = wr_en  && ({1'b0, wr_addr}  < NUM_REGS_W);
    assign rsv_ok   = rsv_en && ({1'b0, rsv_addr} < NUM_REGS_W);
    assign busy_vec = busy;

    // Reserve is applied after the write clear: a same-cycle reservation is a newer producer.
    always_comb begin
        busy_next = busy;
        if (wr_ok)  busy_next[wr_addr]  = 1'b0;
        if (rsv_ok) busy_next[rsv_addr] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) regs[wr_addr] <= wr_data;
            busy <= busy_next;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        reg_file_rd_port #(
            .WORD_SIZE (WORD_SIZE),
            .NUM_REGS  (NUM_REGS),
            .ADDR_W    (ADDR_W)
        ) u_rd_port (
            .CLK       (CLK),
            .RST       (RST),
            .en        (rd_en[p]),
            .addr      (rd_addr[p*ADDR_W +: ADDR_W]),
            .regs      (regs),
            .busy_cur  (busy),
`ifdef REGFILE_BYPASS_EN
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .busy_next (busy_next),
`endif
            .data      (rd_data[p*WORD_SIZE +: WORD_SIZE]),
            .valid     (rd_valid[p]),
            .busy      (rd_busy[p])
        );
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - randomized bench for reg_file_mp against a behavioural model
module tb_reg_file_mp;
    localparam int NR = 6;
    localparam int NP = 2;
    localparam int AW = 3;
    localparam int WS = 19;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [WS-1:0]     wr_data = '0;
    logic              rsv_en = 1'b0;
    logic [AW-1:0]     rsv_addr = '0;
    logic [NP-1:0]     rd_en = '0;
    logic [NP*AW-1:0]  rd_addr = '0;
    logic [NP*WS-1:0]  rd_data;
    logic [NP-1:0]     rd_valid;
    logic [NP-1:0]     rd_busy;
    logic [NR-1:0]     busy_vec;

    int checks = 0;
    int errors = 0;

    logic [WS-1:0] m_reg [NR];
    logic [NR-1:0] m_busy;
    logic [WS-1:0] e_data [NP];
    logic          e_busy [NP];
    logic          e_valid [NP];

    reg_file_mp #(.WORD_SIZE(WS), .NUM_REGS(NR), .NUM_RD(NP)) dut (
        .CLK(CLK), .RST(RST),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
        .busy_vec(busy_vec)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        m_busy = '0;
        for (int p = 0; p < NP; p++) begin
            e_data[p] = '0; e_busy[p] = 1'b0; e_valid[p] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("busy_vec", busy_vec, m_busy);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rd_valid%0d", p), rd_valid[p], e_valid[p]);
            check($sformatf("rd_data%0d", p), rd_data[p*WS +: WS], e_data[p]);
            check($sformatf("rd_busy%0d", p), rd_busy[p], e_busy[p]);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [WS-1:0] wd,
                         input logic se, input logic [AW-1:0] sa, input logic [NP-1:0] re,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [NR-1:0] nb;
        logic [AW-1:0] a;
        bit hit;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = se; rsv_addr = sa;
        rd_en = re; rd_addr = {a1, a0};
        @(posedge CLK);
        nb = m_busy;
        if (we && wa < NR) nb[wa] = 1'b0;
        if (se && sa < NR) nb[sa] = 1'b1;
        for (int p = 0; p < NP; p++) begin
            a = (p == 0) ? a0 : a1;
            e_valid[p] = re[p];
            if (re[p]) begin
                if (a < NR) begin
                    hit = BYP && we && (wa == a);
                    e_data[p] = hit ? wd : m_reg[a];
                    e_busy[p] = hit ? nb[a] : m_busy[a];
                end else begin
                    e_data[p] = '0;
                    e_busy[p] = 1'b0;
                end
            end
        end
        if (we && wa < NR) m_reg[wa] = wd;
        m_busy = nb;
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_data", rd_data, '0);
        check("reset_valid", rd_valid, '0);
        check("reset_busy_vec", busy_vec, '0);
        RST = 1'b0;

        // Preload every register with all-ones, leave reads and a reservation in flight.
        for (int r = 0; r < NR; r++) cycle(1'b1, r[AW-1:0], 19'h7FFFF, 1'b0, 3'd0, 2'b00, 3'd0, 3'd0);
        cycle(1'b0, 3'd0, '0, 1'b1, 3'd4, 2'b11, 3'd5, 3'd2);
        #2 RST = 1'b1;
        #1;
        check("midrst_data", rd_data, '0);
        check("midrst_valid", rd_valid, '0);
        check("midrst_busy_vec", busy_vec, '0);
        model_reset();
        #3 RST = 1'b0;
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, 2'b11, 3'd5, 3'd4);

        // Both ports read the same freshly written register.
        cycle(1'b1, 3'd5, 19'h12345, 1'b0, 3'd0, 2'b00, 3'd0, 3'd0);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, 2'b11, 3'd5, 3'd5);
        check("dual_read_data", rd_data, {2{19'h12345}});
        check("dual_read_valid", rd_valid, 2'b11);

        // Reserve, observe busy on read, then write clears it.
        cycle(1'b0, 3'd0, '0, 1'b1, 3'd3, 2'b00, 3'd0, 3'd0);
        check("rsv_busy_vec3", busy_vec[3], 1'b1);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, 2'b01, 3'd3, 3'd0);
        check("rsv_rd_busy0", rd_busy[0], 1'b1);
        cycle(1'b1, 3'd3, 19'h00ABC, 1'b0, 3'd0, 2'b00, 3'd0, 3'd0);
        check("wr_clears_busy3", busy_vec[3], 1'b0);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, 2'b01, 3'd3, 3'd0);
        check("after_wr_data", rd_data[WS-1:0], 19'h00ABC);
        check("after_wr_busy", rd_busy[0], 1'b0);

        // Same-cycle reserve and write on one register: data lands, busy stays set.
        cycle(1'b1, 3'd2, 19'h00007, 1'b1, 3'd2, 2'b00, 3'd0, 3'd0);
        check("rsv_wr_busy2", busy_vec[2], 1'b1);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, 2'b10, 3'd0, 3'd2);
        check("rsv_wr_data2", rd_data[WS +: WS], 19'h00007);

        // Out-of-range write and read.
        cycle(1'b1, 3'd7, 19'h55555, 1'b1, 3'd6, 2'b00, 3'd0, 3'd0);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, 2'b11, 3'd7, 3'd6);
        check("oor_data", rd_data, '0);
        check("oor_valid", rd_valid, 2'b11);
        for (int r = 0; r < NR; r += 2)
            cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, 2'b11, r[AW-1:0], AW'(r + 1));

        // Same-edge write and read of r1.
        cycle(1'b1, 3'd1, 19'h00001, 1'b0, 3'd0, 2'b00, 3'd0, 3'd0);
        cycle(1'b1, 3'd1, 19'h0F0F0, 1'b0, 3'd0, 2'b01, 3'd1, 3'd0);
        check("same_edge_r1", rd_data[WS-1:0], BYP ? 19'h0F0F0 : 19'h00001);

        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 3'($urandom), 19'($urandom), 1'($urandom_range(0, 3) == 0),
                  3'($urandom), 2'($urandom), 3'($urandom), 3'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
